// File: rtl/game_flow_controller.sv
// Copter game sequencer: owns the game state machine, the internal game tick,
// the running score and the session high score, and drives the run enable.
module game_flow_controller #(
  parameter int TICK_CYCLES     = 25_000_000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int CRASH_TICKS     = 2,
  parameter int SCORE_W         = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               collision,
  output logic [2:0]         state,
  output logic               run,
  output logic               gameover,
  output logic [1:0]         countdown,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);

  localparam int TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CCW = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_CRASH = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t             st_q, st_nxt;
  logic [TCW-1:0]     tick_cnt_q, tick_cnt_nxt;
  logic [CCW-1:0]     crash_cnt_q, crash_cnt_nxt;
  logic [SCORE_W-1:0] score_nxt, high_nxt;
  logic [1:0]         cd_nxt;
  logic               rec_nxt;
  logic               tick_en, tick;
  logic               start_p0, start_p1, pause_p0, pause_p1;
  logic               vld_p0, vld_p1;
  logic               start_edge, pause_edge;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  assign state = st_q;

  // Edge history is qualified by vld_p1 so that a button held through reset
  // only counts once it has been seen released.
  assign start_edge = vld_p1 & start_p0 & ~start_p1;
  assign pause_edge = vld_p1 & pause_p0 & ~pause_p1;

  always_comb begin
    tick_en       = (st_q == S_COUNT) || (st_q == S_RUN) || (st_q == S_CRASH);
    tick          = tick_en && (tick_cnt_q == TCW'(TICK_CYCLES - 1));
    st_nxt        = st_q;
    score_nxt     = score;
    high_nxt      = high_score;
    rec_nxt       = new_record;
    cd_nxt        = countdown;
    crash_cnt_nxt = crash_cnt_q;
    if (tick)         tick_cnt_nxt = '0;
    else if (tick_en) tick_cnt_nxt = tick_cnt_q + TCW'(1);
    else              tick_cnt_nxt = tick_cnt_q;

    case (st_q)
      S_IDLE: begin
        if (start_edge) begin
          st_nxt    = S_COUNT;
          score_nxt = '0;
          cd_nxt    = 2'(COUNTDOWN_TICKS);
        end
      end
      S_COUNT: begin
        if (tick) begin
          if (countdown == 2'd1) begin
            st_nxt = S_RUN;
            cd_nxt = 2'd0;
          end else begin
            cd_nxt = countdown - 2'd1;
          end
        end
      end
      S_RUN: begin
        if (collision) begin
          st_nxt        = S_CRASH;
          crash_cnt_nxt = '0;
          if (score > high_score) begin
            high_nxt = score;
            rec_nxt  = 1'b1;
          end else begin
            rec_nxt  = 1'b0;
          end
        end else if (pause_edge) begin
          st_nxt = S_PAUSE;
        end else if (tick) begin
          score_nxt = sat_inc(score);
        end
      end
      S_PAUSE: begin
        if (pause_edge) st_nxt = S_RUN;
      end
      S_CRASH: begin
        if (tick) begin
          if (crash_cnt_q == CCW'(CRASH_TICKS - 1)) st_nxt = S_OVER;
          else crash_cnt_nxt = crash_cnt_q + CCW'(1);
        end
      end
      S_OVER: begin
        if (start_edge) begin
          st_nxt    = S_COUNT;
          score_nxt = '0;
          rec_nxt   = 1'b0;
          cd_nxt    = 2'(COUNTDOWN_TICKS);
        end
      end
      default: st_nxt = S_IDLE;
    endcase

    // Pause/resume keeps the tick phase; every other transition restarts it.
    if ((st_nxt != st_q) &&
        !((st_q == S_RUN && st_nxt == S_PAUSE) || (st_q == S_PAUSE && st_nxt == S_RUN)))
      tick_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= S_IDLE;
      tick_cnt_q  <= '0;
      crash_cnt_q <= '0;
      score       <= '0;
      high_score  <= '0;
      new_record  <= 1'b0;
      countdown   <= 2'd0;
      run         <= 1'b0;
      gameover    <= 1'b0;
      start_p0    <= 1'b0;
      start_p1    <= 1'b0;
      pause_p0    <= 1'b0;
      pause_p1    <= 1'b0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      // Input sampling stage, then history stage
      start_p0    <= start;
      pause_p0    <= pause;
      vld_p0      <= 1'b1;
      start_p1    <= start_p0;
      pause_p1    <= pause_p0;
      vld_p1      <= vld_p0;
      st_q        <= st_nxt;
      tick_cnt_q  <= tick_cnt_nxt;
      crash_cnt_q <= crash_cnt_nxt;
      score       <= score_nxt;
      high_score  <= high_nxt;
      new_record  <= rec_nxt;
      countdown   <= cd_nxt;
      run         <= (st_nxt == S_RUN);
      gameover    <= (st_nxt == S_CRASH) || (st_nxt == S_OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller with a 4-cycle tick; a second
// 3-bit-score instance covers score saturation and async reset mid-run.
module tb_game_flow_controller;

  localparam int TC = 4;
  localparam int CD = 3;
  localparam int CR = 2;

  logic        clk = 1'b0;
  logic        reset, start, pause, collision;
  logic [2:0]  state;
  logic        run, gameover, new_record;
  logic [1:0]  countdown;
  logic [31:0] score, high_score;

  logic        reset3, start3, pause3, coll3;
  logic [2:0]  state3;
  logic        run3, gameover3, new_record3;
  logic [1:0]  countdown3;
  logic [2:0]  score3, high3;

  always #5 clk = ~clk;

  game_flow_controller #(.TICK_CYCLES(TC), .COUNTDOWN_TICKS(CD), .CRASH_TICKS(CR),
                         .SCORE_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .collision(collision),
    .state(state), .run(run), .gameover(gameover), .countdown(countdown),
    .score(score), .high_score(high_score), .new_record(new_record));

  game_flow_controller #(.TICK_CYCLES(TC), .COUNTDOWN_TICKS(CD), .CRASH_TICKS(CR),
                         .SCORE_W(3)) dut3 (
    .clk(clk), .reset(reset3), .start(start3), .pause(pause3), .collision(coll3),
    .state(state3), .run(run3), .gameover(gameover3), .countdown(countdown3),
    .score(score3), .high_score(high3), .new_record(new_record3));

  typedef struct {
    string       tag;
    int          sig;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] probe(input int sig);
    case (sig)
      0:  return 64'(state);
      1:  return 64'(run);
      2:  return 64'(gameover);
      3:  return 64'(countdown);
      4:  return 64'(score);
      5:  return 64'(high_score);
      6:  return 64'(new_record);
      7:  return 64'(state3);
      8:  return 64'(score3);
      9:  return 64'(high3);
      10: return 64'(run3);
      default: return '1;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, probe(e.sig), e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the expected outputs, advance n cycles, then compare.
  task automatic cyc(input int n, input string tag, input int st, input int cd,
                     input int sc, input int hs, input int nr);
    push({tag, ".state"}, 0, 64'(st));
    push({tag, ".run"}, 1, 64'(st == 2));
    push({tag, ".gameover"}, 2, 64'(st == 4 || st == 5));
    push({tag, ".countdown"}, 3, 64'(cd));
    push({tag, ".score"}, 4, 64'(sc));
    push({tag, ".high"}, 5, 64'(hs));
    push({tag, ".newrec"}, 6, 64'(nr));
    step(n);
    drain();
  endtask

  task automatic cyc3(input int n, input string tag, input int st, input int sc, input int hs);
    push({tag, ".state"}, 7, 64'(st));
    push({tag, ".score"}, 8, 64'(sc));
    push({tag, ".high"}, 9, 64'(hs));
    push({tag, ".run"}, 10, 64'(st == 2));
    step(n);
    drain();
  endtask

  task automatic press_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0; collision = 1'b0;
    reset3 = 1'b0; start3 = 1'b0; pause3 = 1'b0; coll3 = 1'b0;
    step(2);
    cyc(0, "rst", 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(3, "idle", 0, 0, 0, 0, 0);

    // Countdown then scoring
    press_start();
    cyc(1, "t1_count", 1, 3, 0, 0, 0);
    cyc(3, "t1_cd3", 1, 3, 0, 0, 0);
    cyc(1, "t1_cd2", 1, 2, 0, 0, 0);
    cyc(4, "t1_cd1", 1, 1, 0, 0, 0);
    cyc(3, "t1_cd1h", 1, 1, 0, 0, 0);
    cyc(1, "t1_run", 2, 0, 0, 0, 0);
    cyc(3, "t1_s0", 2, 0, 0, 0, 0);
    cyc(1, "t1_s1", 2, 0, 1, 0, 0);
    cyc(4, "t1_s2", 2, 0, 2, 0, 0);
    cyc(4, "t1_s3", 2, 0, 3, 0, 0);

    // Collision on a tick cycle: no increment, first record
    cyc(8, "t2_s5", 2, 0, 5, 0, 0);
    cyc(3, "t2_pre", 2, 0, 5, 0, 0);
    collision = 1'b1;
    cyc(1, "t2_crash", 4, 0, 5, 5, 1);
    collision = 1'b0;
    cyc(7, "t2_crashh", 4, 0, 5, 5, 1);
    cyc(1, "t2_over", 5, 0, 5, 5, 1);

    // Lower score, then equal score: no high-score update
    press_start();
    cyc(1, "t3_count", 1, 3, 0, 5, 0);
    cyc(12, "t3_run", 2, 0, 0, 5, 0);
    cyc(12, "t3_s3", 2, 0, 3, 5, 0);
    collision = 1'b1;
    cyc(1, "t3_crash", 4, 0, 3, 5, 0);
    collision = 1'b0;
    cyc(8, "t3_over", 5, 0, 3, 5, 0);
    press_start();
    cyc(1, "t3b_count", 1, 3, 0, 5, 0);
    cyc(12, "t3b_run", 2, 0, 0, 5, 0);
    cyc(20, "t3b_s5", 2, 0, 5, 5, 0);
    collision = 1'b1;
    cyc(1, "t3b_crash", 4, 0, 5, 5, 0);
    collision = 1'b0;
    cyc(8, "t3b_over", 5, 0, 5, 5, 0);

    // Pause with tick phase 2, collision ignored while paused
    press_start();
    cyc(1, "t4_count", 1, 3, 0, 5, 0);
    cyc(12, "t4_run", 2, 0, 0, 5, 0);
    step(1);
    pause = 1'b1;
    cyc(1, "t4_armed", 2, 0, 0, 5, 0);
    pause = 1'b0;
    cyc(1, "t4_pause", 3, 0, 0, 5, 0);
    collision = 1'b1;
    cyc(20, "t4_hold", 3, 0, 0, 5, 0);
    collision = 1'b0;
    pause = 1'b1;
    cyc(1, "t4_unp", 3, 0, 0, 5, 0);
    pause = 1'b0;
    cyc(1, "t4_resume", 2, 0, 0, 5, 0);
    cyc(1, "t4_tick", 2, 0, 1, 5, 0);

    // Reset mid-game with start held; held start gives no edge
    reset = 1'b0;
    start = 1'b1;
    #1;
    cyc(0, "t5_rst", 0, 0, 0, 0, 0);
    step(2);
    reset = 1'b1;
    cyc(5, "t5_held", 0, 0, 0, 0, 0);
    start = 1'b0;
    step(2);
    press_start();
    cyc(1, "t5_count", 1, 3, 0, 0, 0);
    cyc(12, "t5_run", 2, 0, 0, 0, 0);
    start = 1'b1;
    cyc(10, "t5_norestart", 2, 0, 2, 0, 0);
    start = 1'b0;

    // 3-bit score saturation, then async reset mid-run
    reset3 = 1'b1;
    step(3);
    start3 = 1'b1;
    step(1);
    start3 = 1'b0;
    cyc3(1, "t6_count", 1, 0, 0);
    cyc3(12, "t6_run", 2, 0, 0);
    cyc3(24, "t6_s6", 2, 6, 0);
    cyc3(4, "t6_s7", 2, 7, 0);
    cyc3(8, "t6_sat", 2, 7, 0);
    reset3 = 1'b0;
    #1;
    cyc3(0, "t6_rst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
